fwd_scoreboard: RTL

Parametrised hazard and forwarding unit for the pipelined MIPS core. It keeps a shadow pipeline of in-flight register writes, each with a Tnew countdown, and compares the decode-stage instruction's reads, each with its own Tuse, against it. From this it generates the global `stall` and one decode-stage forwarding select per read port. It replaces hand-written per-stage address compares and sits beside the D/E pipeline register, alongside the hazard controller it absorbs.

---
 rtl/fwd_pkg.sv | 27 ++
 rtl/md_busy_cnt.sv | 35 +++
 rtl/fwd_scoreboard.sv | 120 ++++++++++++
 3 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: shared types and constants for the forwarding scoreboard.
//   fwd_ent_t  - one shadow-pipeline entry {vld, addr, tnew}
//   FWD_*      - forwarding select encodings (0 = register file, k+1 = entry k)
//   TNEW_*     - Tnew values for the common producer classes
//   tnew_dec() - saturating Tnew decrement
package fwd_pkg;

   typedef struct packed {
      logic       vld;
      logic [4:0] addr;
      logic [1:0] tnew;
   } fwd_ent_t;

   localparam int unsigned FWD_ORIGIN = 0;
   localparam int unsigned FWD_E      = 1;
   localparam int unsigned FWD_M      = 2;
   localparam int unsigned FWD_W      = 3;

   localparam logic [1:0] TNEW_ALU = 2'd1;
   localparam logic [1:0] TNEW_LD  = 2'd2;
   localparam logic [1:0] TNEW_PC8 = 2'd0;

   function automatic logic [1:0] tnew_dec(input logic [1:0] t);
      return (t == 2'd0) ? 2'd0 : t - 2'd1;
   endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// md_busy_cnt: mult/div occupancy counter.
//   clk, rst_n  - clock, asynchronous active-low reset
//   md_start    - mult/div issued this cycle (loads the counter)
//   md_is_div   - selects DIV_LAT instead of MULT_LAT on md_start
//   md_busy     - unit occupied: md_start | (count != 0)
module md_busy_cnt #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic md_start,
   input  logic md_is_div,
   output logic md_busy
);

   localparam int unsigned MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
   localparam int unsigned CW      = $clog2(MAX_LAT + 1);

   logic [CW-1:0] cnt_q;

   // A start while busy simply reloads: the newest operation owns HI/LO.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (md_start) begin
         cnt_q <= md_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CW'(1);
      end
   end

   assign md_busy = md_start | (cnt_q != '0);

endmodule

// File: rtl/fwd_scoreboard.sv
// fwd_scoreboard: hazard detection and decode-stage forwarding selection.
// Keeps a shadow pipeline of in-flight GPR writes (entry 0 = E, 1 = M, 2 = W),
// each with a Tnew countdown, and checks the decode instruction's reads
// against it.
//   clk, rst_n             - clock, asynchronous active-low reset
//   d_valid/d_rd_en/...    - decode instruction reads (addr, Tuse) and write
//   d_md_use               - decode instruction needs HI/LO or the MD unit
//   md_start, md_is_div    - mult/div issued from E this cycle
//   flush                  - invalidates all shadow entries
//   stall                  - freeze PC and F/D, bubble into E
//   fwd_sel                - per read port: 0 = regfile, k+1 = entry k
//   md_busy                - mult/div unit occupied
// Optional feature: define FWD_SB_MD_EN to compile in the MD busy counter
// and MD stall; otherwise md_busy is 0 and the MD inputs are ignored.
module fwd_scoreboard
   import fwd_pkg::*;
#(
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_STG  = 3,
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10,
   localparam int unsigned SEL_W   = $clog2(NUM_STG + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    d_valid,
   input  logic [NUM_RD-1:0]       d_rd_en,
   input  logic [NUM_RD*5-1:0]     d_rd_addr,
   input  logic [NUM_RD*2-1:0]     d_tuse,
   input  logic                    d_wr_en,
   input  logic [4:0]              d_wr_addr,
   input  logic [1:0]              d_tnew,
   input  logic                    d_md_use,
   input  logic                    md_start,
   input  logic                    md_is_div,
   input  logic                    flush,
   output logic                    stall,
   output logic [NUM_RD*SEL_W-1:0] fwd_sel,
   output logic                    md_busy
);

   fwd_ent_t          ent_q [NUM_STG];
   fwd_ent_t          ent_d [NUM_STG];
   logic              stall_rd;
   logic              md_stall;
   logic [NUM_RD-1:0] hit;

   // Shadow pipeline advances every edge; a stall turns the new E entry into a bubble.
   always_comb begin
      for (int k = 0; k < NUM_STG; k++) begin
         ent_d[k] = '0;
      end
      if (!flush) begin
         ent_d[0].vld  = d_valid & d_wr_en & ~stall;
         ent_d[0].addr = d_wr_addr;
         ent_d[0].tnew = d_tnew;
         for (int k = 1; k < NUM_STG; k++) begin
            ent_d[k]      = ent_q[k-1];
            ent_d[k].tnew = tnew_dec(ent_q[k-1].tnew);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_STG; k++) begin
            ent_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_STG; k++) begin
            ent_q[k] <= ent_d[k];
         end
      end
   end

   // Only the nearest (lowest-index) matching producer counts; older ones are shadowed.
   // A non-zero Tnew that is still within Tuse leaves fwd_sel at 0: a later stage forwards.
   always_comb begin
      stall_rd = 1'b0;
      fwd_sel  = '0;
      hit      = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         for (int k = 0; k < NUM_STG; k++) begin
            if (!hit[p] && d_rd_en[p] && (d_rd_addr[p*5 +: 5] != 5'd0) &&
                ent_q[k].vld && (ent_q[k].addr == d_rd_addr[p*5 +: 5])) begin
               hit[p] = 1'b1;
               if (ent_q[k].tnew > d_tuse[p*2 +: 2]) begin
                  stall_rd = 1'b1;
               end else if (ent_q[k].tnew == 2'd0) begin
                  fwd_sel[p*SEL_W +: SEL_W] = SEL_W'(k + 1);
               end
            end
         end
      end
   end

`ifdef FWD_SB_MD_EN
   md_busy_cnt #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_md_busy_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .md_start  (md_start),
      .md_is_div (md_is_div),
      .md_busy   (md_busy)
   );

   assign md_stall = d_md_use & md_busy;
`else
   logic md_unused;

   assign md_unused = md_start ^ md_is_div ^ d_md_use;
   assign md_busy   = 1'b0;
   assign md_stall  = 1'b0;
`endif

   assign stall = stall_rd | md_stall;

endmodule
